// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the serial right-shift sequencer: default widths
// and the controller state encoding.
package shift_sequencer_pkg;

  // Default datapath and shift-amount widths.
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_AMT_W = 5;

  // Controller states. The encoding is fixed so that other blocks and
  // debug tooling can decode the raw two-bit value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : shift_sequencer_pkg

// File: rtl/sra_step_unit.sv
// One-bit right shift: purely combinational. The vacated MSB takes the old
// MSB when arithmetic fill is selected, otherwise zero.
module sra_step_unit
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_arith,
  output logic [WIDTH-1:0] o_data
);

  logic w_fill;

  // Sign fill only when arithmetic mode is selected.
  assign w_fill = i_arith & i_data[WIDTH-1];

  // Drop the LSB and insert the fill bit at the top.
  assign o_data = {w_fill, i_data[WIDTH-1:1]};

endmodule : sra_step_unit

// File: rtl/shift_sequencer.sv
// Multi-cycle right shifter. An accepted operand is shifted one bit per
// clock until the requested amount is exhausted; the result is then held
// until the consumer takes it. flush aborts any operation in progress.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = DEFAULT_AMT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_arith,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_result;
  logic [AMT_W-1:0]   r_count;
  logic               r_arith;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_accept;
  logic               w_step;
  logic               w_count_last;

  // An accept needs an idle controller and no concurrent abort.
  assign w_accept     = in_valid && (r_state == IDLE) && !flush;
  // A shift step happens on every SHIFT cycle that is not being aborted.
  assign w_step       = (r_state == SHIFT) && !flush;
  // The current SHIFT cycle is the one that takes the count from 1 to 0.
  assign w_count_last = (r_count == AMT_W'(1));

  sra_step_unit #(
    .WIDTH (WIDTH)
  ) u_sra_step (
    .i_data  (r_result),
    .i_arith (r_arith),
    .o_data  (w_shifted)
  );

  // State register.
  // NOTE: clocked state always uses non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; flush overrides both accept and consumption.
  // NOTE: the default assignment first guarantees every path drives
  // w_next_state, so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (flush) begin
          w_next_state = IDLE;
        end else if (w_count_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: capture the operation on accept, then step it in SHIFT.
  // NOTE: these datapath registers are reset on purpose so out_data reads
  // zero during and after reset rather than leftover operand bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_count  <= '0;
      r_arith  <= 1'b0;
    end else if (w_accept) begin
      r_result <= in_data;
      r_count  <= in_amt;
      r_arith  <= in_arith;
    end else if (w_step) begin
      r_result <= w_shifted;
      r_count  <= r_count - AMT_W'(1);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_result;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer. Accepted operations push their
// expected result and due cycle; an independent monitor compares whenever
// the sequencer presents or hands off a result.
module tb_shift_sequencer;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               due;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_arith;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int   cyc          = 0;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   n_handshakes = 0;
  exp_t q[$];
  logic prev_ov      = 1'b0;
  logic expect_idle  = 1'b0;

  shift_sequencer #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_arith  (in_arith),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Reference: whole shift in one step with the language's own operators.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [AMT_W-1:0] a,
                                                 input logic ar);
    logic [WIDTH-1:0] r;
    if (ar) r = WIDTH'($signed(d) >>> a);
    else    r = d >> a;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, decides what the next rising
  // edge will do, and checks outputs against the scoreboard.
  always @(negedge clock) begin
    if (!reset_n) begin
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_out_data", out_data, 32'd0);
      q.delete();
      prev_ov     = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        check("idle_after_end", 32'({in_ready, out_valid}), 32'b10);
        expect_idle = 1'b0;
      end
      check("busy_vs_ready", 32'(busy), 32'(!in_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!prev_ov) check("latency", cyc, q[0].due);
          check("out_data", out_data, q[0].res);
          check("in_ready_in_done", 32'(in_ready), 32'd0);
        end
      end
      if (flush) begin
        q.delete();
        expect_idle = 1'b1;
      end else if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        n_handshakes++;
        expect_idle = 1'b1;
      end else if (in_valid && in_ready) begin
        q.push_back('{res: ref_shift(in_data, in_amt, in_arith),
                      due: cyc + int'(in_amt) + 1});
      end
      prev_ov = out_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic scramble_inputs();
    in_data  = $urandom;
    in_amt   = AMT_W'($urandom_range(31, 0));
    in_arith = 1'($urandom_range(1, 0));
  endtask

  // Present one operation for a single accepting edge.
  task automatic issue(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                       input logic ar, input logic early_ready);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      step(1);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_arith  = ar;
    out_ready = early_ready;
    step(1);
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_out_valid(output bit ok);
    int guard = 0;
    while (!out_valid && guard < 40) begin
      step(1);
      guard++;
    end
    ok = out_valid;
    if (!ok) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Full operation: accept, wait for the result, stall, then consume.
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                        input logic ar, input int stall, input logic early_ready);
    bit ok;
    issue(d, a, ar, early_ready);
    wait_out_valid(ok);
    if (!ok) begin
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      return;
    end
    if (!early_ready) begin
      step(stall);
      out_ready = 1'b1;
    end
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_before;
    bit ok;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    scramble_inputs();
    #1;
    check("por_out_data", out_data, 32'd0);
    check("por_in_ready", 32'(in_ready), 32'd1);
    #21;
    reset_n = 1'b1;
    step(2);

    // Directed corner cases: full-width sign fill, zero fill, zero amount,
    // and a long consumer stall.
    run_op(32'h8000_0000, 5'd31, 1'b1, 0, 1'b1);
    run_op(32'h8000_0000, 5'd31, 1'b0, 0, 1'b1);
    run_op(32'h1234_5678, 5'd0,  1'b0, 0, 1'b1);
    run_op(32'hF000_0000, 5'd4,  1'b1, 5, 1'b0);

    // Asynchronous reset in the middle of a 20-bit shift.
    issue(32'h8765_4321, 5'd20, 1'b1, 1'b0);
    step(6);
    #2;
    reset_n = 1'b0;
    q.delete();
    #1;
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", out_data, 32'd0);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    step(30);

    // Flush during SHIFT, then flush in DONE alongside out_ready.
    hs_before = n_handshakes;
    issue(32'hCAFE_F00D, 5'd10, 1'b0, 1'b0);
    step(3);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(15);
    issue(32'h0F0F_0F0F, 5'd2, 1'b1, 1'b0);
    wait_out_valid(ok);
    flush     = 1'b1;
    out_ready = 1'b1;
    step(1);
    flush     = 1'b0;
    out_ready = 1'b0;
    step(3);
    check("flush_no_handshake", n_handshakes, hs_before);
    run_op(32'h0000_0100, 5'd8, 1'b0, 1, 1'b0);

    // Randomized traffic with varying stalls and idle gaps.
    for (int i = 0; i < 30; i++) begin
      run_op($urandom, AMT_W'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
             int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      step(int'($urandom_range(2, 0)));
    end

    step(5);
    check("scoreboard_drained", q.size(), 32'd0);
    check("handshake_total", n_handshakes, hs_before + 31);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_shift_sequencer

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width in bits.
REQ-002 SHALL have parameter AMT_W, default 5: shift-amount width; maximum amount is 2^AMT_W-1.
REQ-003 SHALL have port clock  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: requester presents an operation.
REQ-006 SHALL have port in_ready  output  1: sequencer can accept an operation.
REQ-007 SHALL have port in_data  input  WIDTH: operand to shift.
REQ-008 SHALL have port in_amt  input  AMT_W: right-shift amount.
REQ-009 SHALL have port in_arith  input  1: 1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-010 SHALL have port flush  input  1: synchronous abort of any operation.
REQ-011 SHALL have port out_valid  output  1: result available.
REQ-012 SHALL have port out_ready  input  1: consumer takes the result.
REQ-013 SHALL have port out_data  output  WIDTH: shifted result.
REQ-014 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 SHALL accept an operation when in_valid && in_ready at a rising edge, capturing in_data, in_amt and in_arith into internal registers.
REQ-017 On accept with in_amt==0, SHALL go IDLE->DONE with the result register equal to in_data (latency 1 cycle).
REQ-018 On accept with in_amt!=0, SHALL go IDLE->SHIFT with remaining-count register = in_amt.
REQ-019 In SHIFT, SHALL per cycle shift the result register right by exactly one bit, filling the MSB with the old MSB if arith=1, else with 0, and decrement the count.
REQ-020 SHALL transition SHIFT->DONE on the cycle that the count goes from 1 to 0; total latency from accept to out_valid = in_amt+1 cycles.
REQ-021 In DONE, SHALL hold out_data stable until out_valid && out_ready, then go to IDLE on that edge.
REQ-022 SHALL not accept a new operation in the same cycle a result is consumed; the earliest next accept is one cycle after DONE->IDLE.
REQ-023 flush high at a rising edge SHALL force IDLE from any state, discarding the operation; flush has priority over accept and over out_ready.
REQ-024 out_data SHALL equal the result register in all states; its value is defined only while out_valid=1.
REQ-025 in_data, in_amt and in_arith SHALL be ignored when no accept occurs.

Reset
REQ-026 reset_n low SHALL immediately set state=IDLE, result register=0, count=0 and arith register=0, independent of clock.
REQ-027 During and after reset: in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL discard the operation without producing out_valid.

Structure
REQ-029 SHALL place the state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the WIDTH/AMT_W defaults in the shared project package.
REQ-030 SHALL instantiate one combinational sub-module sra_step_unit (WIDTH in, fill-select in, WIDTH out) to perform the one-bit right shift; all registers reside in shift_sequencer.

Verification
REQ-031 Accept 0x80000000, amt 31, arith=1, out_ready=1 -> out_valid exactly 32 cycles after accept, out_data=0xFFFFFFFF.
REQ-032 Accept 0x80000000, amt 31, arith=0 -> out_data=0x00000001 after 32 cycles; accept 0x12345678, amt 0 -> out_data=0x12345678 after 1 cycle.
REQ-033 Accept 0xF0000000, amt 4, arith=1, out_ready low for 5 cycles in DONE -> out_data stable at 0xFF000000, in_ready=0 throughout, IDLE one cycle after out_ready rises.
REQ-034 reset_n pulsed low mid-SHIFT (amt 20, cycle 7) -> in_ready=1, out_valid=0, out_data=0 asynchronously; no result emitted afterwards.
REQ-035 flush asserted in SHIFT, and again in DONE together with out_ready=1 -> IDLE next edge, no handshake counted; subsequent accept of 0x00000100, amt 8, arith=0 yields 0x00000001.
